// File: rtl/n25q_spi_flash_if.sv
// Board-level SPI flash bus: controller (master) drives select/data/protect pins,
// flash (slave) drives the serial data out.
interface n25q_spi_flash_if;
  logic S;
  logic DQ0;
  logic DQ1;
  logic Vpp_W_DQ2;
  logic HOLD_DQ3;

  modport master (output S, DQ0, Vpp_W_DQ2, HOLD_DQ3, input DQ1);
  modport slave  (input S, DQ0, Vpp_W_DQ2, HOLD_DQ3, output DQ1);
endinterface

// File: rtl/n25q_spi_flash.sv
// Behavioural SPI NOR flash slave (N25Q command subset, mode 0) over a 2^MEM_AW byte store.
// Optional 4-byte addressing (opcode 0xB7) is built when FOUR_BYTE_ADDR_EN is defined.
module n25q_spi_flash #(
  parameter int unsigned MEM_AW       = 12,
  parameter int unsigned SUBSECTOR_AW = 12
) (
  input logic             C_,
  input logic             resetb,
  n25q_spi_flash_if.slave bus
);

  typedef enum logic [2:0] {CMD, ADDR, DATA_IN, DATA_OUT, IGNORE} state_e;
  typedef enum logic [2:0] {K_READ, K_PP, K_SE, K_RDSR, K_ID, K_NVW, K_NVR} kind_e;

  localparam logic [MEM_AW-1:0] SS_MASK = MEM_AW'((1 << SUBSECTOR_AW) - 1);

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        sr_q, sr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        nv_lo_q, nv_lo_d;
  logic              wel_q, wel_d;
  logic [15:0]       nv_cfg_q, nv_cfg_d;
  logic              swp_q, swp_d;
  logic [MEM_AW-1:0] swp_addr_q, swp_addr_d;
  logic [MEM_AW-1:0] swp_last_q, swp_last_d;
  logic              dq1_q, dq1_d;
  logic [7:0]        mem_q [2**MEM_AW];

  logic              mem_we;
  logic [MEM_AW-1:0] mem_wa;
  logic [7:0]        mem_wd;
  logic [7:0]        byte_in, out_byte;
  logic              byte_done;
  logic [1:0]        last_abyte;
  logic [MEM_AW-1:0] addr_shift;
  logic              unused_hold;

`ifdef FOUR_BYTE_ADDR_EN
  logic four_q, four_d;
  always_ff @(posedge C_ or negedge resetb) begin
    if (!resetb) four_q <= 1'b0;
    else         four_q <= four_d;
  end
`else
  logic four_q;
  assign four_q = 1'b0;
`endif

  assign unused_hold = bus.HOLD_DQ3;
  assign byte_in     = {sr_q, bus.DQ0};
  assign byte_done   = (bit_cnt_q == 3'd7);
  assign last_abyte  = four_q ? 2'd3 : 2'd2;
  assign addr_shift  = MEM_AW'({addr_q, byte_in});

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    sr_d       = byte_in[6:0];
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    nv_lo_d    = nv_lo_q;
    wel_d      = wel_q;
    nv_cfg_d   = nv_cfg_q;
    swp_d      = swp_q;
    swp_addr_d = swp_addr_q;
    swp_last_d = swp_last_q;
`ifdef FOUR_BYTE_ADDR_EN
    four_d     = four_q;
`endif
    mem_we     = 1'b0;
    mem_wa     = addr_q;
    mem_wd     = byte_in;

    // Erase sweep runs on any clock with S low, independent of the current transaction.
    if (swp_q && !bus.S) begin
      mem_we     = 1'b1;
      mem_wa     = swp_addr_q;
      mem_wd     = 8'hFF;
      swp_addr_d = swp_addr_q + MEM_AW'(1);
      if (swp_addr_q == swp_last_q) begin
        swp_d = 1'b0;
        wel_d = 1'b0;
      end
    end

    if (byte_done) begin
      cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
      case (state_q)
        CMD: begin
          cnt_d   = '0;
          state_d = IGNORE;
          if (swp_q) begin
            if (byte_in == 8'h05) begin state_d = DATA_OUT; kind_d = K_RDSR; end
          end else begin
            case (byte_in)
              8'h03: begin state_d = ADDR; kind_d = K_READ; end
              8'h02: if (wel_q) begin state_d = ADDR; kind_d = K_PP; end
              8'h20: if (wel_q) begin state_d = ADDR; kind_d = K_SE; end
              8'h06: wel_d = 1'b1;
              8'h04: wel_d = 1'b0;
              8'h05: begin state_d = DATA_OUT; kind_d = K_RDSR; end
              8'h9E: begin state_d = DATA_OUT; kind_d = K_ID; end
              8'hB1: begin state_d = DATA_IN;  kind_d = K_NVW; end
              8'hB5: begin state_d = DATA_OUT; kind_d = K_NVR; end
              8'hC7: if (wel_q && bus.Vpp_W_DQ2) begin
                swp_d      = 1'b1;
                swp_addr_d = '0;
                swp_last_d = '1;
              end
`ifdef FOUR_BYTE_ADDR_EN
              8'hB7: four_d = 1'b1;
`endif
              default: ;
            endcase
          end
        end
        ADDR: begin
          addr_d = addr_shift;
          if (cnt_q == last_abyte) begin
            cnt_d = '0;
            case (kind_q)
              K_READ:  state_d = DATA_OUT;
              K_PP:    state_d = DATA_IN;
              default: begin
                state_d    = IGNORE;
                swp_d      = 1'b1;
                swp_addr_d = addr_shift & ~SS_MASK;
                swp_last_d = addr_shift | SS_MASK;
              end
            endcase
          end
        end
        DATA_IN: begin
          if (kind_q == K_PP) begin
            mem_we      = 1'b1;
            addr_d[7:0] = addr_q[7:0] + 8'd1;
            // WEL drops at the first programmed byte; nothing can observe it before S rises.
            wel_d       = 1'b0;
          end else if (cnt_q == 2'd0) begin
            nv_lo_d = byte_in;
          end else begin
            nv_cfg_d = {byte_in, nv_lo_q};
            state_d  = IGNORE;
          end
        end
        DATA_OUT: if (kind_q == K_READ) addr_d = addr_q + MEM_AW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    out_byte = 8'h00;
    case (kind_q)
      K_READ: out_byte = mem_q[addr_q];
      K_RDSR: out_byte = {1'b1, 5'b00000, wel_q, swp_q};
      K_ID: case (cnt_q)
        2'd0:    out_byte = 8'h20;
        2'd1:    out_byte = 8'hBA;
        2'd2:    out_byte = 8'h19;
        default: out_byte = 8'h00;
      endcase
      K_NVR: case (cnt_q)
        2'd0:    out_byte = nv_cfg_q[7:0];
        2'd1:    out_byte = nv_cfg_q[15:8];
        default: out_byte = 8'h00;
      endcase
      default: out_byte = 8'h00;
    endcase
    dq1_d = (state_q == DATA_OUT) ? out_byte[~bit_cnt_q] : 1'b0;
  end

  always_ff @(posedge C_ or negedge resetb or posedge bus.S) begin
    if (!resetb) begin
      state_q <= CMD;  kind_q <= K_READ; bit_cnt_q <= '0;
      sr_q    <= '0;   cnt_q  <= '0;     addr_q    <= '0; nv_lo_q <= '0;
    end else if (bus.S) begin
      state_q <= CMD;  kind_q <= K_READ; bit_cnt_q <= '0;
      sr_q    <= '0;   cnt_q  <= '0;     addr_q    <= '0; nv_lo_q <= '0;
    end else begin
      state_q <= state_d; kind_q <= kind_d; bit_cnt_q <= bit_cnt_d;
      sr_q    <= sr_d;    cnt_q  <= cnt_d;  addr_q    <= addr_d; nv_lo_q <= nv_lo_d;
    end
  end

  always_ff @(posedge C_ or negedge resetb) begin
    if (!resetb) begin
      wel_q      <= 1'b0;
      nv_cfg_q   <= 16'hFFFF;
      swp_q      <= 1'b0;
      swp_addr_q <= '0;
      swp_last_q <= '0;
    end else begin
      wel_q      <= wel_d;
      nv_cfg_q   <= nv_cfg_d;
      swp_q      <= swp_d;
      swp_addr_q <= swp_addr_d;
      swp_last_q <= swp_last_d;
    end
  end

  always_ff @(posedge C_) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_ff @(negedge C_ or negedge resetb or posedge bus.S) begin
    if (!resetb)     dq1_q <= 1'b0;
    else if (bus.S)  dq1_q <= 1'b0;
    else             dq1_q <= dq1_d;
  end

  assign bus.DQ1 = dq1_q;

endmodule

// File: tb/tb_n25q_spi_flash.sv
// Directed bench for n25q_spi_flash: vector table of SPI transactions plus
// hand-written erase, abort and reset sequences.
module tb_n25q_spi_flash;

  logic clk = 1'b0;
  logic rstb;

  n25q_spi_flash_if bus ();

  n25q_spi_flash #(.MEM_AW(12), .SUBSECTOR_AW(12)) dut (
    .C_    (clk),
    .resetb(rstb),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] tx;
    int unsigned ntx;
    logic [31:0] exp;
    int unsigned nexp;
    logic        vpp;
  } vec_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  vec_t        vecs [18];

  function automatic vec_t mk(input string name, input logic [63:0] tx, input int unsigned ntx,
                              input logic [31:0] exp, input int unsigned nexp, input logic vpp);
    vec_t v;
    v.name = name;
    v.tx   = tx << (8 * (8 - ntx));
    v.ntx  = ntx;
    v.exp  = (nexp == 0) ? 32'h0 : (exp << (8 * (4 - nexp)));
    v.nexp = nexp;
    v.vpp  = vpp;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic sel();
    @(negedge clk); #1;
    bus.S = 1'b0;
  endtask

  task automatic desel();
    bus.S   = 1'b1;
    bus.DQ0 = 1'b0;
    @(negedge clk); #1;
  endtask

  // Called at falling edge + 1: samples DQ1 then presents the next MOSI bit.
  task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      rx[i]   = bus.DQ1;
      bus.DQ0 = tx[i];
      @(posedge clk); @(negedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] rx;
    bus.Vpp_W_DQ2 = v.vpp;
    sel();
    for (int b = 0; b < int'(v.ntx); b++) xbyte(v.tx[63 - 8 * b -: 8], rx);
    for (int b = 0; b < int'(v.nexp); b++) begin
      xbyte(8'h00, rx);
      check($sformatf("%s[%0d]", v.name, b), rx, v.exp[31 - 8 * b -: 8]);
    end
    desel();
    bus.Vpp_W_DQ2 = 1'b1;
  endtask

  // Whole-array sweep: 4096 clocks with S low, so WIP should clear near poll byte 511.
  task automatic poll_wip(input string name);
    logic [7:0]  rx;
    int unsigned j;
    bit          done;
    sel();
    xbyte(8'h05, rx);
    xbyte(8'h00, rx);
    check({name, "_wip_first"}, rx, 8'h83);
    j = 0;
    done = 1'b0;
    while (!done && j < 2000) begin
      j++;
      xbyte(8'h00, rx);
      if (!rx[0]) done = 1'b1;
    end
    desel();
    n_tests++;
    if (!done || j < 505 || j > 515) begin
      n_fail++;
      $display("FAIL %s_sweep_len: WIP cleared at poll byte %0d (done=%0d) expected about 511", name, j, done);
    end
    check({name, "_wip_last"}, rx, 8'h80);
  endtask

  initial begin
    logic [7:0] rx;
    rstb          = 1'b0;
    bus.S         = 1'b1;
    bus.DQ0       = 1'b0;
    bus.Vpp_W_DQ2 = 1'b1;
    bus.HOLD_DQ3  = 1'b1;

    vecs[0]  = mk("rdsr_reset",  64'h05,             1, 32'h80,       1, 1'b1);
    vecs[1]  = mk("rdid",        64'h9E,             1, 32'h20BA1900, 4, 1'b1);
    vecs[2]  = mk("wren",        64'h06,             1, 32'h0,        0, 1'b1);
    vecs[3]  = mk("rdsr_wel",    64'h05,             1, 32'h82,       1, 1'b1);
    vecs[4]  = mk("wrdi",        64'h04,             1, 32'h0,        0, 1'b1);
    vecs[5]  = mk("rdsr_wrdi",   64'h05,             1, 32'h8080,     2, 1'b1);
    vecs[6]  = mk("wren",        64'h06,             1, 32'h0,        0, 1'b1);
    vecs[7]  = mk("pp_fe",       64'h020000FEA1B2C3, 7, 32'h0,        0, 1'b1);
    vecs[8]  = mk("rd_fe",       64'h030000FE,       4, 32'hA1B2,     2, 1'b1);
    vecs[9]  = mk("rd_wrap",     64'h03000000,       4, 32'hC3,       1, 1'b1);
    vecs[10] = mk("rdsr_pp",     64'h05,             1, 32'h80,       1, 1'b1);
    vecs[11] = mk("wrnvcr",      64'hB13412,         3, 32'h0,        0, 1'b1);
    vecs[12] = mk("rdnvcr",      64'hB5,             1, 32'h341200,   3, 1'b1);
    vecs[13] = mk("unknown_op",  64'hFF,             1, 32'h00,       1, 1'b1);
    vecs[14] = mk("wren",        64'h06,             1, 32'h0,        0, 1'b1);
    vecs[15] = mk("be_novpp",    64'hC7,             1, 32'h0,        0, 1'b0);
    vecs[16] = mk("rdsr_novpp",  64'h05,             1, 32'h8282,     2, 1'b1);
    vecs[17] = mk("rd_novpp",    64'h030000FE,       4, 32'hA1B2,     2, 1'b1);

    #23 rstb = 1'b1;
    repeat (2) @(negedge clk);

    check("dq1_idle", bus.DQ1, 1'b0);
    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // Bulk erase with write-protect released
    run_vec(mk("wrdi",     64'h04,         1, 32'h0,      0, 1'b1));
    run_vec(mk("wren",     64'h06,         1, 32'h0,      0, 1'b1));
    run_vec(mk("be",       64'hC7,         1, 32'h0,      0, 1'b1));
    poll_wip("be");
    run_vec(mk("rdsr_be",  64'h05,         1, 32'h80,     1, 1'b1));
    run_vec(mk("rd_be_0",  64'h03000000,   4, 32'hFF,     1, 1'b1));
    run_vec(mk("rd_be_fe", 64'h030000FE,   4, 32'hFFFF,   2, 1'b1));
    run_vec(mk("rd_be_top",64'h03000FFE,   4, 32'hFFFFFF, 3, 1'b1));

    // Program without WEL is ignored; then program and subsector-erase
    run_vec(mk("pp_nowel", 64'h0200001055, 5, 32'h0,      0, 1'b1));
    run_vec(mk("rd_nowel", 64'h03000010,   4, 32'hFF,     1, 1'b1));
    run_vec(mk("wren",     64'h06,         1, 32'h0,      0, 1'b1));
    run_vec(mk("pp_10",    64'h020000105A, 5, 32'h0,      0, 1'b1));
    run_vec(mk("rd_10",    64'h03000010,   4, 32'h5AFF,   2, 1'b1));
    run_vec(mk("wren",     64'h06,         1, 32'h0,      0, 1'b1));
    run_vec(mk("se",       64'h20000020,   4, 32'h0,      0, 1'b1));
    poll_wip("se");
    run_vec(mk("rd_se",    64'h03000010,   4, 32'hFF,     1, 1'b1));
    run_vec(mk("wren",     64'h06,         1, 32'h0,      0, 1'b1));
    run_vec(mk("pp_3c",    64'h020000103C, 5, 32'h0,      0, 1'b1));

`ifdef FOUR_BYTE_ADDR_EN
    run_vec(mk("en4b",     64'hB7,         1, 32'h0,      0, 1'b1));
    run_vec(mk("rd_4b",    64'h0300000010, 5, 32'h3CFF,   2, 1'b1));
`else
    run_vec(mk("b7_unk",   64'hB7,         1, 32'h00,     1, 1'b1));
    run_vec(mk("rd_3b",    64'h03000010,   4, 32'h3CFF,   2, 1'b1));
`endif

    // Seven bits of WREN then deselect: the partial byte must not act
    sel();
    for (int i = 7; i >= 1; i--) begin
      bus.DQ0 = 8'h06 >> i;
      @(posedge clk); @(negedge clk); #1;
    end
    desel();
    run_vec(mk("rdsr_abort", 64'h05,       1, 32'h80,     1, 1'b1));

    // Reset restores config and status
    run_vec(mk("wren",     64'h06,         1, 32'h0,      0, 1'b1));
    rstb = 1'b0;
    #20 rstb = 1'b1;
    @(negedge clk); #1;
    run_vec(mk("rdnvcr_rst", 64'hB5,       1, 32'hFFFF,   2, 1'b1));
    run_vec(mk("rdsr_rst2",  64'h05,       1, 32'h80,     1, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/n25q_spi_flash.md
Name: n25q_spi_flash

Overview:
- Behavioural, synthesizable SPI NOR flash slave modelled on the Micron N25Q command set, mode 0 only.
- Sits on the board-level SPI bus opposite the flash controller and serves as the simulation target for controller read, program, erase, ID and configuration traffic.
- Backing store is a small parameterised byte array; addresses wrap modulo its size.

Parameters:
- MEM_AW, 12, byte-address width of the backing store (depth 2^MEM_AW; higher address bits ignored).
- SUBSECTOR_AW, 12, subsector size 2^SUBSECTOR_AW bytes; must be <= MEM_AW.

Ports:
- C_  input  1  SPI serial clock; the single clock of the block.
- resetb  input  1  asynchronous active-low reset.
- S  input  1  chip select, active low; high aborts or ends a transaction asynchronously.
- DQ0  input  1  serial data in (MOSI).
- DQ1  output  1  serial data out (MISO).
- Vpp_W_DQ2  input  1  write-protect; low blocks bulk erase.
- HOLD_DQ3  input  1  hold; accepted and ignored.

Behaviour:
- Sampling and output timing:
  - DQ0 is shifted in MSB-first on rising C_.
  - DQ1 updates on falling C_, MSB-first.
  - DQ1 is 0 when S is high, during command and address bytes, and after any response data is exhausted.
- Reset (resetb low):
  - Transaction state returns to CMD.
  - Status = 0x80 (bit7 SRWD=1, bits6..2=0, bit1 WEL=0, bit0 WIP=0).
  - nv_config = 0xFFFF; 4-byte mode off; no erase in progress.
  - Memory contents are undefined until erased.
- S high: bit/byte counters clear and state returns to CMD; WEL, WIP, nv_config, the erase sweep and memory are kept.
- States and byte counting:
  - States: CMD, ADDR, DATA_IN, DATA_OUT, IGNORE.
  - A byte completes on the 8th rising C_ after S falls, and on every 8th rising edge thereafter.
- Opcode 0x03 READ:
  - Takes 3 address bytes MSB-first (4 in 4-byte mode).
  - After the last address byte, output streams mem[addr], mem[addr+1], ..., wrapping at 2^MEM_AW, until S rises.
  - First data bit appears on the falling edge following the last address bit.
- Opcode 0x02 PAGE PROGRAM:
  - Takes address bytes, then each subsequent full byte is written to mem[waddr].
  - Only waddr[7:0] increments, so writes wrap within the 256-byte page.
  - Requires WEL=1 at opcode time; otherwise the transaction goes to IGNORE.
  - WEL clears when S rises after at least one byte was written.
- Opcode 0x06 WREN sets WEL; opcode 0x04 WRDI clears WEL.
- Opcode 0x05 RDSR: outputs the status byte, repeated each byte while S stays low.
- Opcode 0x9E READ ID: outputs 0x20, 0xBA, 0x19, then 17 bytes of 0x00, then 0.
- Opcode 0xB1 WRNVCR: takes 2 bytes, first byte = nv_config[7:0], second = nv_config[15:8]. Updates only when the 2nd byte completes; WEL not required.
- Opcode 0xB5 RDNVCR: outputs nv_config[7:0], then nv_config[15:8].
- Opcode 0x20 SUBSECTOR ERASE:
  - Takes address bytes; requires WEL=1.
  - Sets WIP and starts an erase sweep over the subsector containing addr (base = addr with low SUBSECTOR_AW bits cleared).
- Opcode 0xC7 BULK ERASE:
  - Requires WEL=1 and Vpp_W_DQ2=1; otherwise ignored and WIP stays 0.
  - Sweeps the whole array.
- Erase sweep:
  - Writes 0xFF to one byte per rising C_ while S is low, in any transaction.
  - WIP reads 1 throughout the sweep.
  - On the final byte, WIP and WEL clear.
  - While WIP=1, every opcode except 0x05 is treated as unknown.
- Unknown opcodes, and aborted or partial bytes when S rises: go to IGNORE, output 0, no state change.
- Reset mid-sweep cancels the sweep; the partially erased region stays as-is.

Optional Feature:
- Macro FOUR_BYTE_ADDR_EN.
- When defined:
  - Opcode 0xB7 enables 4-byte address mode (sticky until reset).
  - 0x02, 0x03 and 0x20 then take 4 address bytes.
  - READ data output begins after byte 5 instead of byte 4.
- When undefined:
  - 0xB7 is treated as unknown.
  - Addresses are always 3 bytes.

Test Plan:
- Reset then RDSR (0x05) -> DQ1 = 0x80; then 0x9E -> 0x20, 0xBA, 0x19, 0x00.
- WREN, then RDSR -> 0x82; then WRDI, then RDSR -> 0x80.
- WREN; PAGE PROGRAM 0x02 to addr 0x0000FE with data A1, B2, C3 -> READ 0x03 at 0x0000FE returns A1, B2 and READ at 0x000000 returns C3 (page wrap); RDSR afterwards -> 0x80.
- WREN, then 0xC7 with Vpp_W_DQ2=1; poll RDSR -> WIP=1 until the sweep completes, then 0x80; READ anywhere -> 0xFF. Repeat with Vpp_W_DQ2=0 -> WIP never sets and data is unchanged.
- WRNVCR 0xB1 with bytes 0x34, 0x12 -> RDNVCR 0xB5 returns 0x34, 0x12; reset -> returns 0xFF, 0xFF.
- With FOUR_BYTE_ADDR_EN: 0xB7, then READ with address 00 00 00 10 -> data from address 0x10, first bit after the 5th byte.
